// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int SB_NREG  = 8;
  localparam int SB_REG_W = 3;

  // EX-stage forwarding mux select, the consumer-side counterpart of this block.
  typedef enum logic [1:0] {
    FWD_ORIG     = 2'b00,
    FWD_MEM_ALU  = 2'b01,
    FWD_EX_ALU   = 2'b10,
    FWD_MEM_DATA = 2'b11
  } fwd_sel_e;

  // Instruction word loaded into ID/EX when a bubble is inserted.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Decode control outputs, in port order.
  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic bubble_id_ex;
    logic issue_id;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// One scoreboard entry: saturating down-counter with load override and freeze.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  // Load wins over the decrement; freeze holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (freeze)        cnt <= cnt;
    else if (load)          cnt <= load_val;
    else if (cnt != '0)     cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage load-use hazard detector with per-register countdown scoreboard.
// Optional HAZARD_STATS_EN adds saturating stall / memory-stall cycle counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG     = SB_NREG,
  parameter int REG_W    = SB_REG_W,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             validId,
  input  logic [REG_W-1:0] RsId,
  input  logic [REG_W-1:0] RtId,
  input  logic             RsValidId,
  input  logic             RtValidId,
  input  logic             RegWriteId,
  input  logic             MemReadId,
  input  logic [REG_W-1:0] writeRegId,
  input  logic             memStall,
  input  logic             flush,
`ifdef HAZARD_STATS_EN
  output logic [15:0]      stallCount,
  output logic [15:0]      memStallCount,
`endif
  output logic             stallPc,
  output logic             stallIfId,
  output logic             bubbleIdEx,
  output logic             issueId
);

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            load_en;
  logic [CNT_W-1:0]           load_val;
  logic [REG_W-1:0]           last_dest;
  logic                       last_valid;
  logic                       hazard, issue_wr, clear_last;
  hz_ctrl_t                   ctrl;

  assign hazard = validId & ((RsValidId & (cnt[RsId] != '0)) |
                             (RtValidId & (cnt[RtId] != '0)));

  // Priority memStall > flush > hazard; reset forces everything quiet.
  always_comb begin
    ctrl = '0;
    if (!rst_n)      ctrl = '0;
    else if (memStall) begin
      ctrl.stall_pc    = 1'b1;
      ctrl.stall_if_id = 1'b1;
    end else if (flush) begin
      ctrl.bubble_id_ex = 1'b1;
    end else if (hazard) begin
      ctrl.stall_pc     = 1'b1;
      ctrl.stall_if_id  = 1'b1;
      ctrl.bubble_id_ex = 1'b1;
    end else begin
      ctrl.issue_id = validId;
    end
  end

  assign stallPc    = ctrl.stall_pc;
  assign stallIfId  = ctrl.stall_if_id;
  assign bubbleIdEx = ctrl.bubble_id_ex;
  assign issueId    = ctrl.issue_id;

  assign issue_wr   = ctrl.issue_id & RegWriteId;
  // A flushed load in EX will never produce its value, so its entry is cleared.
  assign clear_last = flush & ~memStall & last_valid;
  assign load_val   = (issue_wr & MemReadId) ? CNT_W'(LOAD_LAT) : '0;

  // Per-entry load select: new writer, or flush-clear of the load now in EX.
  always_comb begin
    load_en = '0;
    for (int r = 0; r < NREG; r++)
      load_en[r] = (issue_wr   && (writeRegId == REG_W'(r))) ||
                   (clear_last && (last_dest  == REG_W'(r)));
  end

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .freeze   (memStall),
      .load     (load_en[r]),
      .load_val (load_val),
      .cnt      (cnt[r])
    );
  end

  // Track the instruction entering EX; only a pending load needs flush cleanup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dest  <= '0;
      last_valid <= 1'b0;
    end else if (!memStall) begin
      if (issue_wr) begin
        last_dest  <= writeRegId;
        last_valid <= MemReadId;
      end else begin
        last_valid <= 1'b0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating cycle counters for hazard stalls and memory freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount    <= '0;
      memStallCount <= '0;
    end else begin
      if (hazard && !memStall && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
      if (memStall && memStallCount != 16'hFFFF)
        memStallCount <= memStallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: LOAD_LAT=1 instance (u1) and LOAD_LAT=2 instance (u2) on shared stimulus.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       validId, RsValidId, RtValidId, RegWriteId, MemReadId, memStall, flush;
  logic [2:0] RsId, RtId, writeRegId;
  logic       sp1, si1, b1, i1, sp2, si2, b2, i2;
  logic [3:0] o1, o2;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, mc1, sc2, mc2;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] IDLE = 4'b0000, ISS = 4'b0001, HAZ = 4'b1110,
                         FL = 4'b0010, MS = 4'b1100;

  always #5 clk = ~clk;

  assign o1 = {sp1, si1, b1, i1};
  assign o2 = {sp2, si2, b2, i2};

  hazard_scoreboard #(.NREG(8), .REG_W(3), .LOAD_LAT(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .validId(validId), .RsId(RsId), .RtId(RtId),
    .RsValidId(RsValidId), .RtValidId(RtValidId), .RegWriteId(RegWriteId),
    .MemReadId(MemReadId), .writeRegId(writeRegId), .memStall(memStall), .flush(flush),
`ifdef HAZARD_STATS_EN
    .stallCount(sc1), .memStallCount(mc1),
`endif
    .stallPc(sp1), .stallIfId(si1), .bubbleIdEx(b1), .issueId(i1));

  hazard_scoreboard #(.NREG(8), .REG_W(3), .LOAD_LAT(2), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .validId(validId), .RsId(RsId), .RtId(RtId),
    .RsValidId(RsValidId), .RtValidId(RtValidId), .RegWriteId(RegWriteId),
    .MemReadId(MemReadId), .writeRegId(writeRegId), .memStall(memStall), .flush(flush),
`ifdef HAZARD_STATS_EN
    .stallCount(sc2), .memStallCount(mc2),
`endif
    .stallPc(sp2), .stallIfId(si2), .bubbleIdEx(b2), .issueId(i2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // v, rs, rsv, rt, rtv, regwrite, memread, wr, memstall, flush
  task automatic drive(input logic v, input logic [2:0] rs, input logic rsv,
                       input logic [2:0] rt, input logic rtv, input logic rw,
                       input logic mr, input logic [2:0] wr, input logic ms,
                       input logic fl);
    validId = v; RsId = rs; RsValidId = rsv; RtId = rt; RtValidId = rtv;
    RegWriteId = rw; MemReadId = mr; writeRegId = wr; memStall = ms; flush = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_u1", 16'(o1), 16'(IDLE));
    chk("reset_u2", 16'(o2), 16'(IDLE));
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_after_reset", 16'(o1), 16'(IDLE));
    tick();

    // load r2 ; add r3,r2,r4 back to back
    drive(1, 0, 1, 0, 0, 1, 1, 2, 0, 0); chk("A_load", 16'(o1), 16'(ISS)); tick();
    drive(1, 2, 1, 4, 1, 1, 0, 3, 0, 0); chk("A_use_stall_u1", 16'(o1), 16'(HAZ));
                                         chk("A_use_stall_u2", 16'(o2), 16'(HAZ)); tick();
    drive(1, 2, 1, 4, 1, 1, 0, 3, 0, 0); chk("A_use_issue_u1", 16'(o1), 16'(ISS));
                                         chk("A_use_2nd_u2", 16'(o2), 16'(HAZ)); tick();
    idle(2);

    // load r2 ; independent ; use r2
    drive(1, 0, 1, 0, 0, 1, 1, 2, 0, 0); chk("B_load", 16'(o1), 16'(ISS)); tick();
    drive(1, 4, 1, 4, 1, 1, 0, 6, 0, 0); chk("B_indep", 16'(o1), 16'(ISS)); tick();
    drive(1, 2, 1, 0, 0, 1, 0, 3, 0, 0); chk("B_use_dist2", 16'(o1), 16'(ISS)); tick();
    idle(2);

    // load r5 ; flush with r5 consumer ; use r5
    drive(1, 0, 1, 0, 0, 1, 1, 5, 0, 0); chk("C_load", 16'(o1), 16'(ISS)); tick();
    drive(1, 5, 1, 0, 0, 1, 0, 3, 0, 1); chk("C_flush_u1", 16'(o1), 16'(FL));
                                         chk("C_flush_u2", 16'(o2), 16'(FL)); tick();
    drive(1, 5, 1, 0, 0, 1, 0, 3, 0, 0); chk("C_after_flush_u1", 16'(o1), 16'(ISS));
                                         chk("C_cleared_u2", 16'(o2), 16'(ISS)); tick();
    idle(2);

    // load r2 ; consumer frozen by memStall for 3 cycles
    drive(1, 0, 1, 0, 0, 1, 1, 2, 0, 0); chk("D_load", 16'(o1), 16'(ISS)); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 1, 0, 0, 1, 0, 3, 1, 0);
      chk("D_memstall_u1", 16'(o1), 16'(MS));
      chk("D_memstall_u2", 16'(o2), 16'(MS));
      tick();
    end
    drive(1, 2, 1, 0, 0, 1, 0, 3, 0, 0); chk("D_post_u1", 16'(o1), 16'(HAZ));
                                         chk("D_post_u2", 16'(o2), 16'(HAZ)); tick();
    drive(1, 2, 1, 0, 0, 1, 0, 3, 0, 0); chk("D_issue_u1", 16'(o1), 16'(ISS));
                                         chk("D_2nd_u2", 16'(o2), 16'(HAZ)); tick();
    drive(1, 2, 1, 0, 0, 1, 0, 3, 0, 0); chk("D_issue_u2", 16'(o2), 16'(ISS)); tick();
    idle(2);

    // load r1,(r1) ; add r3,r1,r1
    drive(1, 1, 1, 0, 0, 1, 1, 1, 0, 0); chk("E_selfload_u1", 16'(o1), 16'(ISS));
                                         chk("E_selfload_u2", 16'(o2), 16'(ISS)); tick();
    drive(1, 1, 1, 1, 1, 1, 0, 3, 0, 0); chk("E_use_u1", 16'(o1), 16'(HAZ));
                                         chk("E_use_u2", 16'(o2), 16'(HAZ)); tick();
    drive(1, 1, 1, 1, 1, 1, 0, 3, 0, 0); chk("E_issue_u1", 16'(o1), 16'(ISS));
                                         chk("E_2nd_u2", 16'(o2), 16'(HAZ)); tick();
    drive(1, 1, 1, 1, 1, 1, 0, 3, 0, 0); chk("E_issue_u2", 16'(o2), 16'(ISS)); tick();
    idle(2);

    // reset asserted during a load-use stall
    drive(1, 0, 1, 0, 0, 1, 1, 2, 0, 0); chk("F_load", 16'(o1), 16'(ISS)); tick();
    drive(1, 2, 1, 0, 0, 1, 0, 3, 0, 0); chk("F_stall", 16'(o1), 16'(HAZ));
`ifdef HAZARD_STATS_EN
    chk("F_memstall_cnt", mc1, 16'd3);
`endif
    rst_n = 1'b0; #1;
    chk("F_rst_u1", 16'(o1), 16'(IDLE));
    chk("F_rst_u2", 16'(o2), 16'(IDLE));
`ifdef HAZARD_STATS_EN
    chk("F_rst_stallcnt", sc1, 16'd0);
    chk("F_rst_memcnt", mc2, 16'd0);
`endif
    tick();
    rst_n = 1'b1;
    drive(1, 2, 1, 0, 0, 1, 0, 3, 0, 0); chk("F_post_rst_u1", 16'(o1), 16'(ISS));
                                         chk("F_post_rst_u2", 16'(o2), 16'(ISS)); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Decode-stage hazard detector; the producer-side counterpart of the EX-stage forwarding network.
- Tracks in-flight register writes with a per-register countdown scoreboard.
- Decides when the instruction in IF/ID must stall because forwarding cannot yet supply its operand (load-use).
- Also handles data-memory stall freeze and branch-flush cleanup of scoreboard entries.

Parameters:
- NREG, 8, number of architectural registers.
- REG_W, 3, register-ID width (log2 NREG).
- LOAD_LAT, 1, decode stall cycles required when a consumer immediately follows a load (1..3).
- CNT_W, 2, scoreboard counter width; must hold LOAD_LAT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- validId  in  1  IF/ID holds a real instruction.
- RsId  in  REG_W  source register 1 of the decoding instruction.
- RtId  in  REG_W  source register 2 of the decoding instruction.
- RsValidId  in  1  instruction reads Rs.
- RtValidId  in  1  instruction reads Rt.
- RegWriteId  in  1  instruction writes a register.
- MemReadId  in  1  instruction is a load.
- writeRegId  in  REG_W  destination register.
- memStall  in  1  data memory busy; whole pipeline frozen this cycle.
- flush  in  1  branch/jump resolved taken in EX; kill younger work.
- stallPc  out  1  hold PC.
- stallIfId  out  1  hold IF/ID register.
- bubbleIdEx  out  1  load NOP into ID/EX.
- issueId  out  1  instruction advances ID->EX this cycle.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: all cnt[r]=0, lastDest=0, lastValid=0. Outputs are combinational; with validId=0, memStall=0 and flush=0, all outputs are 0.
- Scoreboard state:
  - cnt[0..NREG-1], CNT_W bits each. R0 is an ordinary register.
  - lastDest / lastValid: destination of the instruction issued last cycle, i.e. the one now in EX.
- hazard = validId & ((RsValidId & cnt[RsId]!=0) | (RtValidId & cnt[RtId]!=0)).
- Priority: memStall > flush > hazard.
  - memStall=1: stallPc=1, stallIfId=1, bubbleIdEx=0, issueId=0. All state frozen; no decrement, no flush action.
  - flush=1 (memStall=0): stallPc=0, stallIfId=0, bubbleIdEx=1, issueId=0. If lastValid, cnt[lastDest]<=0. Other counters decrement. lastValid<=0.
  - hazard=1: stallPc=1, stallIfId=1, bubbleIdEx=1, issueId=0. Counters decrement. lastValid<=0.
  - Otherwise: issueId=validId, other outputs 0.
- Counter update on non-frozen cycles:
  - Every cnt[r]!=0 decrements by 1, saturating at 0.
  - On issueId & RegWriteId: cnt[writeRegId] <= MemReadId ? LOAD_LAT : 0. This overrides the decrement of that entry in the same cycle.
  - Also lastDest<=writeRegId, lastValid<=MemReadId (only pending loads need flush clearing).
- Same-cycle case: an instruction that reads and writes the same register (load r1,(r1)) checks the old cnt and then sets the new one.
- Latency: a consumer immediately following a load with LOAD_LAT=1 sees exactly 1 bubble. At distance 2 it sees 0.
- rst_n asserted mid-stall clears all state immediately; the first cycle after release has no hazard.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds output stallCount [15:0], counting cycles with hazard=1 and memStall=0, saturating at 16'hFFFF.
  - Adds output memStallCount [15:0], counting memStall cycles, saturating.
  - Both are reset to 0 by rst_n.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package/include: REG_W, NREG, 2-bit forward-select encodings (00 orig, 01 Mem.aluRes, 10 Ex.aluRes, 11 Mem.memData), NOP encoding used for bubbles.
- One sub-module, sb_counter: a single CNT_W saturating down-counter with load/override and freeze. It is instantiated NREG times through generate.

Test Plan:
- Load r2 issued, then add r3,r2,r4 next cycle (LOAD_LAT=1) -> cycle 1: stallPc=stallIfId=bubbleIdEx=1. Cycle 2: issueId=1, no stall.
- Load r2, independent op, then use r2 -> no stall at any cycle; issueId=1 on all three.
- Load r5 issued, next cycle flush=1 with a r5 consumer in IF/ID -> bubbleIdEx=1, stall=0. cnt[5] cleared, so the following use of r5 does not stall.
- Load-use hazard pending with memStall=1 held 3 cycles -> bubbleIdEx=0, stalls=1, cnt frozen. After release, exactly 1 bubble.
- Load r1,(r1) followed by a use of r1 -> the load itself issues without stall; the consumer sees 1 bubble. Repeat with LOAD_LAT=2 -> 2 bubbles.
- Assert rst_n low during a hazard stall -> outputs drop to 0 immediately and cnt is all 0. With HAZARD_STATS_EN, stallCount=0.
